// File: rtl/video_sync_analyser.sv
// Measures line and frame timing of a sync/blank video stream, declares lock after a run
// of identical frames, and produces registered active-area pixel coordinates.
module video_sync_analyser #(
    parameter int unsigned C_COUNT_WIDTH = 12,
    parameter int unsigned C_LOCK_FRAMES = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_nRst,
    input  logic                     i_nHSync,
    input  logic                     i_nVSync,
    input  logic                     i_nHBlank,
    input  logic                     i_nVBlank,
    output logic                     o_Locked,
    output logic [C_COUNT_WIDTH-1:0] o_HTotal,
    output logic [C_COUNT_WIDTH-1:0] o_VTotal,
    output logic [C_COUNT_WIDTH-1:0] o_Width,
    output logic [C_COUNT_WIDTH-1:0] o_Height,
    output logic [C_COUNT_WIDTH-1:0] o_HSyncWidth,
    output logic [C_COUNT_WIDTH-1:0] o_VSyncLines,
    output logic                     o_FrameStart,
    output logic                     o_Active,
    output logic [C_COUNT_WIDTH-1:0] o_PixelX,
    output logic [C_COUNT_WIDTH-1:0] o_PixelY
);
    typedef logic [C_COUNT_WIDTH-1:0] cnt_t;
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam cnt_t       CNT_ZERO    = {C_COUNT_WIDTH{1'b0}};
    localparam cnt_t       CNT_ONE     = {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam cnt_t       CNT_MAX     = {C_COUNT_WIDTH{1'b1}};
    localparam logic [3:0] LOCK_TARGET = 4'(C_LOCK_FRAMES);

    function automatic cnt_t sat_inc(input cnt_t value);
        if (value == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    state_t     state_q, state_d;
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, first_line_q, first_line_d;
    logic       frame_bad_q, frame_bad_d, locked_q, locked_d, frame_start_q, frame_start_d;
    logic       active_q, active_d;
    logic [3:0] match_q, match_d;
    cnt_t       h_cnt_q, h_cnt_d, line_act_q, line_act_d, prev_total_q, prev_total_d;
    cnt_t       v_cnt_q, v_cnt_d, frame_w_q, frame_w_d, frame_h_q, frame_h_d;
    cnt_t       hs_low_q, hs_low_d, vs_lines_q, vs_lines_d;
    cnt_t       ref_ht_q, ref_ht_d, ref_vt_q, ref_vt_d, ref_w_q, ref_w_d, ref_h_q, ref_h_d;
    cnt_t       htotal_q, htotal_d, vtotal_q, vtotal_d, width_q, width_d, height_q, height_d;
    cnt_t       hsync_width_q, hsync_width_d, vsync_lines_q, vsync_lines_d;
    cnt_t       pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

    logic       h_fall_s, v_fall_s, h_rise_s, v_rise_s, acc_bad_s, meas_match_s, load_s;
    cnt_t       line_total_s, acc_vcnt_s, acc_w_s, acc_h_s, meas_ht_s;

    // Next-state logic for edge detection, measurement accumulators, lock FSM and coordinates
    always_comb begin
        h_fall_s     = hs_prev_q & ~i_nHSync;
        v_fall_s     = vs_prev_q & ~i_nVSync;
        h_rise_s     = ~hs_prev_q & i_nHSync;
        v_rise_s     = ~vs_prev_q & i_nVSync;
        hs_prev_d    = i_nHSync;
        vs_prev_d    = i_nVSync;
        line_total_s = sat_inc(h_cnt_q);
        prev_total_d = prev_total_q;
        first_line_d = first_line_q;

        h_cnt_d    = h_fall_s ? CNT_ZERO : sat_inc(h_cnt_q);
        // Saturation of either horizontal counter poisons the frame being accumulated.
        acc_bad_s  = frame_bad_q
                   | (~h_fall_s & (h_cnt_q == CNT_MAX))
                   | (~h_fall_s & active_q & (line_act_q == CNT_MAX));
        if (h_fall_s) begin
            line_act_d = active_q ? CNT_ONE : CNT_ZERO;
        end else if (active_q) begin
            line_act_d = sat_inc(line_act_q);
        end else begin
            line_act_d = line_act_q;
        end

        acc_vcnt_s = v_cnt_q;
        acc_w_s    = frame_w_q;
        acc_h_s    = frame_h_q;
        if (h_fall_s) begin
            acc_vcnt_s   = sat_inc(v_cnt_q);
            acc_w_s      = (line_act_q > frame_w_q) ? line_act_q : frame_w_q;
            acc_h_s      = (line_act_q != CNT_ZERO) ? sat_inc(frame_h_q) : frame_h_q;
            acc_bad_s    = acc_bad_s | (v_cnt_q == CNT_MAX)
                         | (~first_line_q & (line_total_s != prev_total_q));
            prev_total_d = line_total_s;
            first_line_d = 1'b0;
        end else begin
            prev_total_d = prev_total_q;
        end

        meas_ht_s    = h_fall_s ? line_total_s : prev_total_q;
        meas_match_s = (meas_ht_s == ref_ht_q) && (acc_vcnt_s == ref_vt_q)
                    && (acc_w_s == ref_w_q) && (acc_h_s == ref_h_q);

        if (v_fall_s) begin
            v_cnt_d      = CNT_ZERO;
            frame_w_d    = CNT_ZERO;
            frame_h_d    = CNT_ZERO;
            frame_bad_d  = 1'b0;
            first_line_d = 1'b1;
        end else begin
            v_cnt_d      = acc_vcnt_s;
            frame_w_d    = acc_w_s;
            frame_h_d    = acc_h_s;
            frame_bad_d  = acc_bad_s;
        end

        if (h_fall_s) begin
            hs_low_d = CNT_ONE;
        end else if (!i_nHSync) begin
            hs_low_d = sat_inc(hs_low_q);
        end else begin
            hs_low_d = hs_low_q;
        end
        if (v_fall_s) begin
            vs_lines_d = h_fall_s ? CNT_ONE : CNT_ZERO;
        end else if (h_fall_s && !i_nVSync) begin
            vs_lines_d = sat_inc(vs_lines_q);
        end else begin
            vs_lines_d = vs_lines_q;
        end
        hsync_width_d = (h_rise_s && state_q != ST_SEARCH) ? hs_low_q : hsync_width_q;
        vsync_lines_d = (v_rise_s && state_q != ST_SEARCH) ? vs_lines_q : vsync_lines_q;

        state_d  = state_q;
        match_d  = match_q;
        ref_ht_d = ref_ht_q;
        ref_vt_d = ref_vt_q;
        ref_w_d  = ref_w_q;
        ref_h_d  = ref_h_q;
        load_s   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (v_fall_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_CAPTURE, ST_TRACK, ST_LOCKED: begin
                if (v_fall_s) begin
                    load_s = 1'b1;
                    if (state_q != ST_CAPTURE && meas_match_s && !acc_bad_s) begin
                        match_d = (match_q < LOCK_TARGET) ? match_q + 4'd1 : match_q;
                        state_d = (match_d == LOCK_TARGET) ? ST_LOCKED : state_q;
                    end else begin
                        match_d  = 4'd0;
                        ref_ht_d = meas_ht_s;
                        ref_vt_d = acc_vcnt_s;
                        ref_w_d  = acc_w_s;
                        ref_h_d  = acc_h_s;
                        state_d  = ST_TRACK;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);

        if (load_s) begin
            htotal_d = meas_ht_s;
            vtotal_d = acc_vcnt_s;
            width_d  = acc_w_s;
            height_d = acc_h_s;
        end else begin
            htotal_d = htotal_q;
            vtotal_d = vtotal_q;
            width_d  = width_q;
            height_d = height_q;
        end

        frame_start_d = v_fall_s;
        active_d      = i_nHBlank & i_nVBlank;
        if (active_d) begin
            pixel_x_d = active_q ? sat_inc(pixel_x_q) : CNT_ZERO;
        end else begin
            pixel_x_d = pixel_x_q;
        end
        if (v_fall_s) begin
            pixel_y_d = CNT_ZERO;
        end else if (h_fall_s && line_act_q != CNT_ZERO) begin
            pixel_y_d = sat_inc(pixel_y_q);
        end else begin
            pixel_y_d = pixel_y_q;
        end
    end

    // All state and registered outputs, synchronous active-low reset
    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_q       <= ST_SEARCH;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            first_line_q  <= 1'b1;
            frame_bad_q   <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
            match_q       <= 4'd0;
            h_cnt_q       <= CNT_ZERO;
            line_act_q    <= CNT_ZERO;
            prev_total_q  <= CNT_ZERO;
            v_cnt_q       <= CNT_ZERO;
            frame_w_q     <= CNT_ZERO;
            frame_h_q     <= CNT_ZERO;
            hs_low_q      <= CNT_ZERO;
            vs_lines_q    <= CNT_ZERO;
            ref_ht_q      <= CNT_ZERO;
            ref_vt_q      <= CNT_ZERO;
            ref_w_q       <= CNT_ZERO;
            ref_h_q       <= CNT_ZERO;
            htotal_q      <= CNT_ZERO;
            vtotal_q      <= CNT_ZERO;
            width_q       <= CNT_ZERO;
            height_q      <= CNT_ZERO;
            hsync_width_q <= CNT_ZERO;
            vsync_lines_q <= CNT_ZERO;
            pixel_x_q     <= CNT_ZERO;
            pixel_y_q     <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            first_line_q  <= first_line_d;
            frame_bad_q   <= frame_bad_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
            match_q       <= match_d;
            h_cnt_q       <= h_cnt_d;
            line_act_q    <= line_act_d;
            prev_total_q  <= prev_total_d;
            v_cnt_q       <= v_cnt_d;
            frame_w_q     <= frame_w_d;
            frame_h_q     <= frame_h_d;
            hs_low_q      <= hs_low_d;
            vs_lines_q    <= vs_lines_d;
            ref_ht_q      <= ref_ht_d;
            ref_vt_q      <= ref_vt_d;
            ref_w_q       <= ref_w_d;
            ref_h_q       <= ref_h_d;
            htotal_q      <= htotal_d;
            vtotal_q      <= vtotal_d;
            width_q       <= width_d;
            height_q      <= height_d;
            hsync_width_q <= hsync_width_d;
            vsync_lines_q <= vsync_lines_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
        end
    end

    assign o_Locked     = locked_q;
    assign o_HTotal     = htotal_q;
    assign o_VTotal     = vtotal_q;
    assign o_Width      = width_q;
    assign o_Height     = height_q;
    assign o_HSyncWidth = hsync_width_q;
    assign o_VSyncLines = vsync_lines_q;
    assign o_FrameStart = frame_start_q;
    assign o_Active     = active_q;
    assign o_PixelX     = pixel_x_q;
    assign o_PixelY     = pixel_y_q;
endmodule

// File: tb/tb_video_sync_analyser.sv
// Table-driven bench: each record is one generated frame plus the outputs expected the
// cycle after that frame's opening vsync fall (which closes the previous frame).
module tb_video_sync_analyser;
    localparam int CW    = 12;
    localparam int H_TOT = 48, H_SW = 4, H_A0 = 8, H_ACT = 36;
    localparam int V_TOT = 33, V_SW = 2, V_A0 = 4, V_ACT = 28;
    localparam int K_NORMAL = 0, K_LONG = 1, K_STUCK = 2, K_RESET = 3;
    localparam int N_REC = 19;

    logic          i_Clk = 1'b0, i_nRst = 1'b0;
    logic          i_nHSync = 1'b1, i_nVSync = 1'b1, i_nHBlank = 1'b0, i_nVBlank = 1'b0;
    logic          o_Locked, o_FrameStart, o_Active;
    logic [CW-1:0] o_HTotal, o_VTotal, o_Width, o_Height, o_HSyncWidth, o_VSyncLines;
    logic [CW-1:0] o_PixelX, o_PixelY;
    int            checks = 0, errors = 0;

    typedef struct {
        int kind;
        int locked;
        int ht, vt, w, h, hsw, vsl;
    } rec_t;
    rec_t recs[N_REC];

    video_sync_analyser #(.C_COUNT_WIDTH(CW), .C_LOCK_FRAMES(2)) dut (
        .i_Clk(i_Clk), .i_nRst(i_nRst), .i_nHSync(i_nHSync), .i_nVSync(i_nVSync),
        .i_nHBlank(i_nHBlank), .i_nVBlank(i_nVBlank), .o_Locked(o_Locked),
        .o_HTotal(o_HTotal), .o_VTotal(o_VTotal), .o_Width(o_Width), .o_Height(o_Height),
        .o_HSyncWidth(o_HSyncWidth), .o_VSyncLines(o_VSyncLines), .o_FrameStart(o_FrameStart),
        .o_Active(o_Active), .o_PixelX(o_PixelX), .o_PixelY(o_PixelY)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic rec_t mk(input int kind, input int locked, input int ht);
        rec_t r;
        r.kind = kind;
        r.locked = locked;
        if (ht == 0) begin
            r.ht = 0; r.vt = 0; r.w = 0; r.h = 0; r.hsw = 0; r.vsl = 0;
        end else begin
            r.ht = ht; r.vt = V_TOT; r.w = H_ACT; r.h = V_ACT; r.hsw = H_SW; r.vsl = V_SW;
        end
        return r;
    endfunction

    function automatic int outputs_or();
        return int'(o_Locked | o_FrameStart | o_Active | (|o_HTotal) | (|o_VTotal) | (|o_Width)
                    | (|o_Height) | (|o_HSyncWidth) | (|o_VSyncLines) | (|o_PixelX) | (|o_PixelY));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the following falling edge.
    task automatic drive(input logic hs, input logic vs, input logic hb, input logic vb);
        i_nHSync = hs; i_nVSync = vs; i_nHBlank = hb; i_nVBlank = vb;
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic check_rec(input int r);
        chk($sformatf("rec%0d frame_start", r), int'(o_FrameStart), 1);
        chk($sformatf("rec%0d locked", r), int'(o_Locked), recs[r].locked);
        chk($sformatf("rec%0d htotal", r), int'(o_HTotal), recs[r].ht);
        chk($sformatf("rec%0d vtotal", r), int'(o_VTotal), recs[r].vt);
        chk($sformatf("rec%0d width", r), int'(o_Width), recs[r].w);
        chk($sformatf("rec%0d height", r), int'(o_Height), recs[r].h);
        chk($sformatf("rec%0d hsync_width", r), int'(o_HSyncWidth), recs[r].hsw);
        chk($sformatf("rec%0d vsync_lines", r), int'(o_VSyncLines), recs[r].vsl);
    endtask

    task automatic gen_frame(input int r);
        int   fs, cerr, ltot;
        logic hs, vs, hb, vb;
        fs = 0;
        cerr = 0;
        for (int v = 0; v < V_TOT; v++) begin
            ltot = (recs[r].kind == K_LONG && v == 12) ? H_TOT + 1 : H_TOT;
            for (int h = 0; h < ltot; h++) begin
                hs = (h >= H_SW);
                vs = (v >= V_SW);
                hb = (h >= H_A0 && h < H_A0 + H_ACT);
                vb = (v >= V_A0 && v < V_A0 + V_ACT);
                if (recs[r].kind == K_RESET && v == 10 && h == 20) begin
                    chk("locked_before_mid_reset", int'(o_Locked), 1);
                    i_nRst = 1'b0;
                    drive(hs, vs, hb, vb);
                    i_nRst = 1'b1;
                    chk("outputs_after_mid_reset", outputs_or(), 0);
                end else begin
                    drive(hs, vs, hb, vb);
                end
                if (v == 0 && h == 0) check_rec(r);
                if (o_FrameStart) fs++;
                if (recs[r].kind != K_RESET &&
                    (o_Active != (hb && vb) ||
                     (hb && vb && (int'(o_PixelX) != h - H_A0 || int'(o_PixelY) != v - V_A0))))
                    cerr++;
            end
        end
        if (recs[r].kind == K_STUCK) begin
            repeat (5000) drive(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk($sformatf("frame%0d frame_start_pulses", r), fs, 1);
        if (recs[r].kind != K_RESET) chk($sformatf("frame%0d coord_errors", r), cerr, 0);
    endtask

    initial begin
        recs[0]  = mk(K_NORMAL, 0, 0);
        recs[1]  = mk(K_NORMAL, 0, H_TOT);
        recs[2]  = mk(K_NORMAL, 0, H_TOT);
        recs[3]  = mk(K_NORMAL, 1, H_TOT);
        recs[4]  = mk(K_LONG,   1, H_TOT);
        recs[5]  = mk(K_NORMAL, 0, H_TOT);
        recs[6]  = mk(K_NORMAL, 0, H_TOT);
        recs[7]  = mk(K_NORMAL, 1, H_TOT);
        recs[8]  = mk(K_STUCK,  1, H_TOT);
        recs[9]  = mk(K_NORMAL, 0, 4095);
        recs[10] = mk(K_NORMAL, 0, H_TOT);
        recs[11] = mk(K_NORMAL, 0, H_TOT);
        recs[12] = mk(K_NORMAL, 1, H_TOT);
        recs[13] = mk(K_NORMAL, 1, H_TOT);
        recs[14] = mk(K_RESET,  1, H_TOT);
        recs[15] = mk(K_NORMAL, 0, 0);
        recs[16] = mk(K_NORMAL, 0, H_TOT);
        recs[17] = mk(K_NORMAL, 0, H_TOT);
        recs[18] = mk(K_NORMAL, 1, H_TOT);

        @(negedge i_Clk);
        i_nRst = 1'b0;
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("outputs_in_reset", outputs_or(), 0);
        i_nRst = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("outputs_after_reset_release", outputs_or(), 0);

        for (int r = 0; r < N_REC; r++) gen_frame(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
